// File: rtl/hex_tick_counter.sv
// Single hex digit up/down counter stepped by rising edges of a slow tick
// level sampled on clk_in, with load, enable, wrap pulses and 7-seg output.
module hex_tick_counter #(
    parameter int MAX_COUNT = 15
) (
    input  logic       clk_in,
    input  logic       Reset,
    input  logic       tick_in,
    input  logic       enable,
    input  logic       up_down,
    input  logic       load,
    input  logic [3:0] load_value,
    output logic [3:0] count,
    output logic       carry_out,
    output logic       borrow_out,
    output logic [6:0] seg_out
);

    localparam logic [3:0] MAX_VAL = 4'(MAX_COUNT);

    logic       sync_1_reg, sync_2_reg, tick_prev_reg;
    logic [3:0] count_reg, count_next;
    logic       carry_reg, carry_next;
    logic       borrow_reg, borrow_next;
    logic [6:0] seg_reg, seg_next;
    logic       step;

    // Two-flop synchroniser plus one delayed copy for rising-edge detection
    always_ff @(posedge clk_in or posedge Reset) begin
        if (Reset) begin
            sync_1_reg    <= 1'b0;
            sync_2_reg    <= 1'b0;
            tick_prev_reg <= 1'b0;
        end else begin
            sync_1_reg    <= tick_in;
            sync_2_reg    <= sync_1_reg;
            tick_prev_reg <= sync_2_reg;
        end
    end

    assign step = sync_2_reg & ~tick_prev_reg;

    always_comb begin
        count_next  = count_reg;
        carry_next  = 1'b0;
        borrow_next = 1'b0;
        if (load) begin
            // Out-of-range load values clamp to the terminal count
            count_next = (load_value > MAX_VAL) ? MAX_VAL : load_value;
        end else if (step && enable) begin
            if (up_down) begin
                if (count_reg == MAX_VAL) begin
                    count_next = 4'd0;
                    carry_next = 1'b1;
                end else begin
                    count_next = count_reg + 4'd1;
                end
            end else begin
                if (count_reg == 4'd0) begin
                    count_next  = MAX_VAL;
                    borrow_next = 1'b1;
                end else begin
                    count_next = count_reg - 4'd1;
                end
            end
        end
    end

    always_comb begin
        seg_next = 7'b1000000;
        case (count_reg)
            4'h0: seg_next = 7'b1000000;
            4'h1: seg_next = 7'b1111001;
            4'h2: seg_next = 7'b0100100;
            4'h3: seg_next = 7'b0110000;
            4'h4: seg_next = 7'b0011001;
            4'h5: seg_next = 7'b0010010;
            4'h6: seg_next = 7'b0000010;
            4'h7: seg_next = 7'b1111000;
            4'h8: seg_next = 7'b0000000;
            4'h9: seg_next = 7'b0010000;
            4'hA: seg_next = 7'b0001000;
            4'hB: seg_next = 7'b0000011;
            4'hC: seg_next = 7'b1000110;
            4'hD: seg_next = 7'b0100001;
            4'hE: seg_next = 7'b0000110;
            4'hF: seg_next = 7'b0001110;
            default: seg_next = 7'b1000000;
        endcase
    end

    always_ff @(posedge clk_in or posedge Reset) begin
        if (Reset) begin
            count_reg  <= 4'd0;
            carry_reg  <= 1'b0;
            borrow_reg <= 1'b0;
            seg_reg    <= 7'b1000000;
        end else begin
            count_reg  <= count_next;
            carry_reg  <= carry_next;
            borrow_reg <= borrow_next;
            seg_reg    <= seg_next;
        end
    end

    assign count      = count_reg;
    assign carry_out  = carry_reg;
    assign borrow_out = borrow_reg;
    assign seg_out    = seg_reg;

endmodule

// File: tb/tb_hex_tick_counter.sv
// Directed bench for hex_tick_counter: a MAX_COUNT=15 instance plus a
// MAX_COUNT=9 instance sharing the same stimulus for the clamp case.
module tb_hex_tick_counter;

    logic       clk_in = 1'b0;
    logic       Reset = 1'b1;
    logic       tick_in = 1'b0;
    logic       enable = 1'b0;
    logic       up_down = 1'b1;
    logic       load = 1'b0;
    logic [3:0] load_value = 4'd0;

    logic [3:0] count, count9;
    logic       carry_out, carry9, borrow_out, borrow9;
    logic [6:0] seg_out, seg9;

    int vectors = 0;
    int miscompares = 0;

    logic [6:0] seg_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    always #10 clk_in = ~clk_in;

    hex_tick_counter #(.MAX_COUNT(15)) dut (
        .clk_in(clk_in), .Reset(Reset), .tick_in(tick_in), .enable(enable),
        .up_down(up_down), .load(load), .load_value(load_value),
        .count(count), .carry_out(carry_out), .borrow_out(borrow_out),
        .seg_out(seg_out));

    hex_tick_counter #(.MAX_COUNT(9)) dut9 (
        .clk_in(clk_in), .Reset(Reset), .tick_in(tick_in), .enable(enable),
        .up_down(up_down), .load(load), .load_value(load_value),
        .count(count9), .carry_out(carry9), .borrow_out(borrow9),
        .seg_out(seg9));

    // Raise tick_in and return just after the edge on which count updates
    task automatic rise_to_update();
        tick_in = 1'b1;
        repeat (3) @(negedge clk_in);
    endtask

    // One more edge (seg catches up, pulses clear), then drop tick and settle
    task automatic finish_tick();
        @(negedge clk_in);
        tick_in = 1'b0;
        repeat (3) @(negedge clk_in);
    endtask

    task automatic load_both(input logic [3:0] v);
        load_value = v;
        load = 1'b1;
        @(negedge clk_in);
        load = 1'b0;
        @(negedge clk_in);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            tick_in = ~tick_in;
            #3;
            vectors++;
            if (count !== 4'd0 || carry_out !== 1'b0 || borrow_out !== 1'b0 || seg_out !== 7'b1000000) begin
                miscompares++;
                $display("FAIL reset_hold[%0d]: count=%h carry=%b borrow=%b seg=%b want 0/0/0/1000000",
                         i, count, carry_out, borrow_out, seg_out);
            end
            @(negedge clk_in);
        end
        tick_in = 1'b0;
        Reset = 1'b0;
        repeat (3) @(negedge clk_in);
        vectors++;
        if (count !== 4'd0 || seg_out !== 7'b1000000) begin
            miscompares++;
            $display("FAIL reset_release: count=%h seg=%b want 0/1000000", count, seg_out);
        end
        $display("test_reset: count=%h seg=%b", count, seg_out);
    endtask

    task automatic test_up_wrap();
        logic [3:0] exp;
        enable = 1'b1;
        up_down = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            exp = 4'(i % 16);
            rise_to_update();
            vectors++;
            if (count !== exp || carry_out !== (i == 16) || borrow_out !== 1'b0) begin
                miscompares++;
                $display("FAIL up_step[%0d]: count=%h carry=%b borrow=%b want %h/%b/0",
                         i, count, carry_out, borrow_out, exp, (i == 16));
            end
            finish_tick();
            vectors++;
            if (seg_out !== seg_tab[exp] || carry_out !== 1'b0) begin
                miscompares++;
                $display("FAIL up_seg[%0d]: seg=%b carry=%b want %b/0", i, seg_out, carry_out, seg_tab[exp]);
            end
            $display("test_up_wrap: step %0d count=%h seg=%b", i, count, seg_out);
        end
    endtask

    task automatic test_down_wrap();
        up_down = 1'b0;
        rise_to_update();
        vectors++;
        if (count !== 4'hF || borrow_out !== 1'b1 || carry_out !== 1'b0) begin
            miscompares++;
            $display("FAIL down_wrap: count=%h borrow=%b carry=%b want F/1/0", count, borrow_out, carry_out);
        end
        finish_tick();
        vectors++;
        if (borrow_out !== 1'b0 || seg_out !== 7'b0001110) begin
            miscompares++;
            $display("FAIL down_wrap_after: borrow=%b seg=%b want 0/0001110", borrow_out, seg_out);
        end
        rise_to_update();
        vectors++;
        if (count !== 4'hE || borrow_out !== 1'b0) begin
            miscompares++;
            $display("FAIL down_step: count=%h borrow=%b want E/0", count, borrow_out);
        end
        finish_tick();
        $display("test_down_wrap: count=%h", count);
    endtask

    task automatic test_load_priority();
        up_down = 1'b1;
        enable = 1'b1;
        tick_in = 1'b1;
        repeat (2) @(negedge clk_in);
        load_value = 4'd9;
        load = 1'b1;
        @(negedge clk_in);
        load = 1'b0;
        vectors++;
        if (count !== 4'd9 || carry_out !== 1'b0 || count9 !== 4'd9) begin
            miscompares++;
            $display("FAIL load_vs_step: count=%h carry=%b count9=%h want 9/0/9", count, carry_out, count9);
        end
        finish_tick();
        load_both(4'd12);
        vectors++;
        if (count !== 4'd12 || count9 !== 4'd9) begin
            miscompares++;
            $display("FAIL load_clamp: count=%h count9=%h want C/9", count, count9);
        end
        rise_to_update();
        vectors++;
        if (count9 !== 4'd0 || carry9 !== 1'b1 || count !== 4'd13 || carry_out !== 1'b0) begin
            miscompares++;
            $display("FAIL load_then_step: count9=%h carry9=%b count=%h carry=%b want 0/1/D/0",
                     count9, carry9, count, carry_out);
        end
        finish_tick();
        vectors++;
        if (carry9 !== 1'b0 || seg9 !== 7'b1000000) begin
            miscompares++;
            $display("FAIL load_carry_clear: carry9=%b seg9=%b want 0/1000000", carry9, seg9);
        end
        $display("test_load_priority: count=%h count9=%h", count, count9);
    endtask

    task automatic test_enable_latency();
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rise_to_update();
            finish_tick();
        end
        vectors++;
        if (count !== 4'd13) begin
            miscompares++;
            $display("FAIL enable_gate: count=%h want D", count);
        end
        enable = 1'b1;
        repeat (2) @(negedge clk_in);
        vectors++;
        if (count !== 4'd13) begin
            miscompares++;
            $display("FAIL enable_no_replay: count=%h want D", count);
        end
        tick_in = 1'b1;
        repeat (2) @(negedge clk_in);
        vectors++;
        if (count !== 4'd13) begin
            miscompares++;
            $display("FAIL latency_n1: count=%h want D", count);
        end
        @(negedge clk_in);
        vectors++;
        if (count !== 4'd14 || seg_out !== seg_tab[13]) begin
            miscompares++;
            $display("FAIL latency_n2: count=%h seg=%b want E/%b", count, seg_out, seg_tab[13]);
        end
        @(negedge clk_in);
        vectors++;
        if (seg_out !== seg_tab[14]) begin
            miscompares++;
            $display("FAIL latency_n3: seg=%b want %b", seg_out, seg_tab[14]);
        end
        tick_in = 1'b0;
        repeat (3) @(negedge clk_in);
        $display("test_enable_latency: count=%h seg=%b", count, seg_out);
    endtask

    task automatic test_midop_reset();
        up_down = 1'b1;
        enable = 1'b1;
        load_both(4'd7);
        tick_in = 1'b1;
        repeat (2) @(negedge clk_in);
        Reset = 1'b1;
        #1;
        vectors++;
        if (count !== 4'd0 || carry_out !== 1'b0 || seg_out !== 7'b1000000) begin
            miscompares++;
            $display("FAIL midop_reset: count=%h carry=%b seg=%b want 0/0/1000000", count, carry_out, seg_out);
        end
        @(negedge clk_in);
        vectors++;
        if (count !== 4'd0 || carry_out !== 1'b0) begin
            miscompares++;
            $display("FAIL midop_reset_hold: count=%h carry=%b want 0/0", count, carry_out);
        end
        Reset = 1'b0;
        repeat (3) @(negedge clk_in);
        vectors++;
        if (count !== 4'd1) begin
            miscompares++;
            $display("FAIL release_high_tick: count=%h want 1", count);
        end
        repeat (4) @(negedge clk_in);
        vectors++;
        if (count !== 4'd1 || seg_out !== 7'b1111001) begin
            miscompares++;
            $display("FAIL release_single_step: count=%h seg=%b want 1/1111001", count, seg_out);
        end
        tick_in = 1'b0;
        $display("test_midop_reset: count=%h seg=%b", count, seg_out);
    endtask

    initial begin
        @(negedge clk_in);
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_load_priority();
        test_enable_latency();
        test_midop_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: timeout after %0d vectors", vectors);
        $fatal(1, "timeout");
    end

endmodule
